// File: rtl/csync_decoder.sv
// Composite-sync receiver: recovers hsync/vsync from csync, measures the line period and
// tracks lock against it.
module csync_decoder #(
    parameter int unsigned CW         = 10,
    parameter int unsigned HS_MIN     = 8,
    parameter int unsigned VS_MIN     = 40,
    parameter int unsigned VS_COUNT   = 3,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic          CK,
    input  logic          RN,
    input  logic          csync,
    input  logic          cblank,
    output logic          hs_pulse,
    output logic          vs_pulse,
    output logic [CW-1:0] pix_cnt,
    output logic [CW-1:0] line_cnt,
    output logic [CW-1:0] hperiod,
    output logic          locked,
    output logic          err,
    output logic          active
);

    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] HS_LIM    = CW'(HS_MIN);
    localparam logic [CW-1:0] VS_LIM    = CW'(VS_MIN);
    localparam int unsigned   BW        = $clog2(VS_COUNT + 1);
    localparam int unsigned   MW        = $clog2(LOCK_LINES + 1);
    localparam logic [BW-1:0] BROAD_LIM = BW'(VS_COUNT);
    localparam logic [MW-1:0] MATCH_LIM = MW'(LOCK_LINES);

    typedef enum logic [1:0] {
        StSearch,
        StTrack,
        StLocked
    } state_e;

    state_e        state_q, state_d;
    logic          csync_q, cblank_q, rise_q;
    logic [CW-1:0] low_q, low_d;
    logic [CW-1:0] pix_q, pix_d;
    logic [CW-1:0] line_q, line_d;
    logic [CW-1:0] hperiod_q, hperiod_d;
    logic [BW-1:0] broad_q, broad_d;
    logic [MW-1:0] match_q, match_d;
    logic          miss_q, miss_d;
    logic          skip_q, skip_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          err_q, err_d;

    logic          is_hs, is_broad;
    logic [CW-1:0] pix_inc, period;
    logic [MW-1:0] match_inc;
    logic [BW-1:0] broad_inc;

    // rise_q delays classification one cycle so low_q holds the complete pulse width.
    assign is_hs     = rise_q && (low_q >= HS_LIM) && (low_q < VS_LIM);
    assign is_broad  = rise_q && (low_q >= VS_LIM);
    assign pix_inc   = (pix_q == CNT_MAX) ? CNT_MAX : pix_q + CW'(1);
    // Period includes the cycle in which pix_cnt is cleared.
    assign period    = pix_inc;
    assign match_inc = match_q + MW'(1);
    assign broad_inc = broad_q + BW'(1);

    always_comb begin
        state_d   = state_q;
        low_d     = low_q;
        pix_d     = pix_inc;
        line_d    = line_q;
        hperiod_d = hperiod_q;
        broad_d   = broad_q;
        match_d   = match_q;
        miss_d    = miss_q;
        skip_d    = skip_q;
        hs_d      = 1'b0;
        vs_d      = 1'b0;
        err_d     = 1'b0;

        if (rise_q) begin
            low_d = '0;
        end else if (!csync_q && (low_q != CNT_MAX)) begin
            low_d = low_q + CW'(1);
        end

        if (is_hs) begin
            hs_d    = 1'b1;
            pix_d   = '0;
            line_d  = (line_q == CNT_MAX) ? CNT_MAX : line_q + CW'(1);
            broad_d = '0;
        end

        if (is_broad) begin
            skip_d = 1'b1;
            if (broad_inc == BROAD_LIM) begin
                vs_d    = 1'b1;
                line_d  = '0;
                broad_d = '0;
            end else begin
                broad_d = broad_inc;
            end
        end

        if (is_hs) begin
            unique case (state_q)
                StSearch: begin
                    hperiod_d = period;
                    match_d   = '0;
                    skip_d    = 1'b1;
                    state_d   = StTrack;
                end
                StTrack: begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (period == hperiod_q) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_LIM) begin
                            state_d = StLocked;
                        end
                    end else begin
                        hperiod_d = period;
                        match_d   = '0;
                    end
                end
                StLocked: begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (period == hperiod_q) begin
                        miss_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_q) begin
                            state_d = StSearch;
                            match_d = '0;
                            miss_d  = 1'b0;
                        end else begin
                            miss_d = 1'b1;
                        end
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        // A line that never ends drops back to searching without flagging an error.
        if (pix_d == CNT_MAX) begin
            state_d = StSearch;
            match_d = '0;
            miss_d  = 1'b0;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q   <= StSearch;
            csync_q   <= 1'b0;
            cblank_q  <= 1'b0;
            rise_q    <= 1'b0;
            low_q     <= '0;
            pix_q     <= '0;
            line_q    <= '0;
            hperiod_q <= '0;
            broad_q   <= '0;
            match_q   <= '0;
            miss_q    <= 1'b0;
            skip_q    <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            csync_q   <= csync;
            cblank_q  <= cblank;
            rise_q    <= ~csync_q & csync;
            low_q     <= low_d;
            pix_q     <= pix_d;
            line_q    <= line_d;
            hperiod_q <= hperiod_d;
            broad_q   <= broad_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            skip_q    <= skip_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            err_q     <= err_d;
        end
    end

    assign hs_pulse = hs_q;
    assign vs_pulse = vs_q;
    assign pix_cnt  = pix_q;
    assign line_cnt = line_q;
    assign hperiod  = hperiod_q;
    assign locked   = (state_q == StLocked);
    assign err      = err_q;
    assign active   = locked & ~cblank_q & csync_q;

endmodule

// File: tb/tb_csync_decoder.sv
// Directed bench for csync_decoder: reset, lock, glitch, vertical interval, period change,
// loss of sync and asynchronous reset.
module tb_csync_decoder;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic       csync = 1'b1;
    logic       cblank = 1'b0;
    logic       hs_pulse, vs_pulse, locked, err, active;
    logic [9:0] pix_cnt, line_cnt, hperiod;
    logic [34:0] outs;

    int n_vec = 0;
    int n_bad = 0;
    int hs_n, vs_n, err_n, hs_at, vs_at, err_at;
    logic [9:0] pix_obs [1:1200];
    logic [9:0] lc_obs  [1:1200];
    logic       act_obs [1:1200];
    logic       lk_obs  [1:1200];

    csync_decoder dut (
        .CK       (CK),
        .RN       (RN),
        .csync    (csync),
        .cblank   (cblank),
        .hs_pulse (hs_pulse),
        .vs_pulse (vs_pulse),
        .pix_cnt  (pix_cnt),
        .line_cnt (line_cnt),
        .hperiod  (hperiod),
        .locked   (locked),
        .err      (err),
        .active   (active)
    );

    assign outs = {hs_pulse, vs_pulse, pix_cnt, line_cnt, hperiod, locked, err, active};

    always #5 CK = ~CK;

    // One line: csync low for `low` cycles, optional 5-cycle glitch at offset `glitch`.
    task automatic run_line(input int period, input int low, input int glitch);
        hs_n = 0; vs_n = 0; err_n = 0; hs_at = 0; vs_at = 0; err_at = 0;
        for (int j = 0; j < period; j++) begin
            csync  = ((j < low) || (glitch > 0 && j >= glitch && j < glitch + 5)) ? 1'b0 : 1'b1;
            cblank = (j < 20);
            @(negedge CK);
            if (hs_pulse) begin hs_n++; if (hs_at == 0) hs_at = j + 1; end
            if (vs_pulse) begin vs_n++; if (vs_at == 0) vs_at = j + 1; end
            if (err) begin err_n++; if (err_at == 0) err_at = j + 1; end
            pix_obs[j+1] = pix_cnt;
            lc_obs[j+1]  = line_cnt;
            act_obs[j+1] = active;
            lk_obs[j+1]  = locked;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            csync = ~csync;
            @(negedge CK);
            n_vec++;
            if (outs !== 35'd0) begin
                n_bad++; $display("FAIL reset_hold: outputs %h, required 0", outs);
            end
        end
        csync = 1'b1;
        RN = 1'b1;
        #1;
        n_vec++;
        if (pix_cnt !== 10'd0) begin
            n_bad++; $display("FAIL reset_pix0: pix_cnt %0d, required 0", pix_cnt);
        end
        repeat (3) @(negedge CK);
        n_vec++;
        if (pix_cnt !== 10'd3) begin
            n_bad++; $display("FAIL reset_pix3: pix_cnt %0d, required 3", pix_cnt);
        end
        repeat (85) @(negedge CK);
    endtask

    task automatic test_lock();
        int err_tot = 0;
        for (int l = 1; l <= 6; l++) begin
            run_line(100, 10, 0);
            err_tot += err_n;
            n_vec++;
            if (hs_at !== 12 || hs_n !== 1) begin
                n_bad++; $display("FAIL lock_hs line %0d: at %0d count %0d, required at 12 count 1",
                                  l, hs_at, hs_n);
            end
            if (l == 5) begin
                n_vec++;
                if (locked !== 1'b0) begin
                    n_bad++; $display("FAIL lock_early: locked %b, required 0", locked);
                end
            end
        end
        n_vec++;
        if (lk_obs[11] !== 1'b0 || lk_obs[12] !== 1'b1) begin
            n_bad++; $display("FAIL lock_edge: locked %b->%b, required 0->1", lk_obs[11], lk_obs[12]);
        end
        n_vec++;
        if (hperiod !== 10'd100) begin
            n_bad++; $display("FAIL lock_hperiod: %0d, required 100", hperiod);
        end
        n_vec++;
        if (line_cnt !== 10'd6) begin
            n_bad++; $display("FAIL lock_line_cnt: %0d, required 6", line_cnt);
        end
        n_vec++;
        if (err_tot !== 0) begin
            n_bad++; $display("FAIL lock_err: %0d strobes, required 0", err_tot);
        end
    endtask

    task automatic test_glitch();
        run_line(100, 10, 62);
        n_vec++;
        if (hs_n !== 1 || err_n !== 0) begin
            n_bad++; $display("FAIL glitch_strobes: hs %0d err %0d, required hs 1 err 0", hs_n, err_n);
        end
        n_vec++;
        if (pix_obs[70] !== 10'd58 || pix_obs[100] !== 10'd88) begin
            n_bad++; $display("FAIL glitch_pix: %0d/%0d, required 58/88", pix_obs[70], pix_obs[100]);
        end
        n_vec++;
        if ({act_obs[15], act_obs[30], act_obs[65]} !== 3'b010) begin
            n_bad++; $display("FAIL glitch_active: %b%b%b, required 010",
                              act_obs[15], act_obs[30], act_obs[65]);
        end
        run_line(100, 10, 0);
        n_vec++;
        if (err_n !== 0 || hperiod !== 10'd100 || locked !== 1'b1) begin
            n_bad++; $display("FAIL glitch_next: err %0d hperiod %0d locked %b, required 0 100 1",
                              err_n, hperiod, locked);
        end
        n_vec++;
        if (line_cnt !== 10'd8) begin
            n_bad++; $display("FAIL glitch_line_cnt: %0d, required 8", line_cnt);
        end
    endtask

    task automatic test_vertical();
        int pre = 0;
        for (int b = 1; b <= 3; b++) begin
            run_line(50, 45, 0);
            if (b < 3) pre += vs_n + hs_n;
            else pre += hs_n;
        end
        n_vec++;
        if (pre !== 0) begin
            n_bad++; $display("FAIL vert_early: %0d strobes, required 0", pre);
        end
        n_vec++;
        if (vs_n !== 1 || vs_at !== 47) begin
            n_bad++; $display("FAIL vert_vs: count %0d at %0d, required 1 at 47", vs_n, vs_at);
        end
        n_vec++;
        if (lc_obs[47] !== 10'd0) begin
            n_bad++; $display("FAIL vert_line_cnt: %0d, required 0", lc_obs[47]);
        end
        run_line(100, 10, 0);
        n_vec++;
        if (err_n !== 0 || locked !== 1'b1 || hs_at !== 12) begin
            n_bad++; $display("FAIL vert_first_hs: err %0d locked %b hs_at %0d, required 0 1 12",
                              err_n, locked, hs_at);
        end
        run_line(100, 10, 0);
        n_vec++;
        if (err_n !== 0 || locked !== 1'b1 || line_cnt !== 10'd2) begin
            n_bad++; $display("FAIL vert_resume: err %0d locked %b line_cnt %0d, required 0 1 2",
                              err_n, locked, line_cnt);
        end
    endtask

    task automatic test_period_change();
        int err_tot = 0;
        run_line(120, 10, 0);
        n_vec++;
        if (err_n !== 0) begin
            n_bad++; $display("FAIL pchg_a: err %0d, required 0", err_n);
        end
        run_line(120, 10, 0);
        n_vec++;
        if (err_n !== 1 || err_at !== 12 || locked !== 1'b1) begin
            n_bad++; $display("FAIL pchg_b: err %0d at %0d locked %b, required 1 at 12 locked 1",
                              err_n, err_at, locked);
        end
        run_line(120, 10, 0);
        n_vec++;
        if (err_n !== 1 || lk_obs[11] !== 1'b1 || lk_obs[12] !== 1'b0) begin
            n_bad++; $display("FAIL pchg_c: err %0d locked %b->%b, required 1 and 1->0",
                              err_n, lk_obs[11], lk_obs[12]);
        end
        for (int l = 1; l <= 6; l++) begin
            run_line(120, 10, 0);
            err_tot += err_n;
            if (l == 5) begin
                n_vec++;
                if (locked !== 1'b0) begin
                    n_bad++; $display("FAIL pchg_early: locked %b, required 0", locked);
                end
            end
        end
        n_vec++;
        if (locked !== 1'b1 || hperiod !== 10'd120 || err_tot !== 0) begin
            n_bad++; $display("FAIL pchg_relock: locked %b hperiod %0d err %0d, required 1 120 0",
                              locked, hperiod, err_tot);
        end
    endtask

    task automatic test_loss_of_sync();
        int err_tot = 0;
        csync  = 1'b1;
        cblank = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            @(negedge CK);
            if (err) err_tot++;
            if (n == 914) begin
                n_vec++;
                if (pix_cnt !== 10'd1022 || locked !== 1'b1) begin
                    n_bad++; $display("FAIL los_1022: pix %0d locked %b, required 1022 1",
                                      pix_cnt, locked);
                end
            end
            if (n == 915) begin
                n_vec++;
                if (pix_cnt !== 10'd1023 || locked !== 1'b0) begin
                    n_bad++; $display("FAIL los_1023: pix %0d locked %b, required 1023 0",
                                      pix_cnt, locked);
                end
            end
        end
        n_vec++;
        if (pix_cnt !== 10'd1023 || err_tot !== 0) begin
            n_bad++; $display("FAIL los_hold: pix %0d err %0d, required 1023 0", pix_cnt, err_tot);
        end
        n_vec++;
        if (line_cnt !== 10'd11 || hperiod !== 10'd120) begin
            n_bad++; $display("FAIL los_state: line_cnt %0d hperiod %0d, required 11 120",
                              line_cnt, hperiod);
        end
    endtask

    task automatic test_async_reset();
        run_line(50, 10, 0);
        #2 RN = 1'b0;
        #1;
        n_vec++;
        if (outs !== 35'd0) begin
            n_bad++; $display("FAIL areset_clear: outputs %h, required 0", outs);
        end
        repeat (2) @(negedge CK);
        csync = 1'b1;
        RN = 1'b1;
        repeat (88) @(negedge CK);
        run_line(100, 10, 0);
        run_line(100, 10, 0);
        n_vec++;
        if (hperiod !== 10'd100 || locked !== 1'b0 || line_cnt !== 10'd2) begin
            n_bad++; $display("FAIL areset_search: hperiod %0d locked %b line_cnt %0d, required 100 0 2",
                              hperiod, locked, line_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_glitch();
        test_vertical();
        test_period_change();
        test_loss_of_sync();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
